// File: rtl/sys_clk_ctrl_pkg.sv
// sys_clk_ctrl_pkg: mode/state encodings shared by the clock-enable controller and its bench
package sys_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10,
        MODE_HALT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    // STEP and BURST both park in IDLE; BURST leaves it only on a trigger
    function automatic state_e base_state(mode_e m);
        return m == MODE_RUN ? ST_RUN : m == MODE_HALT ? ST_HALT : ST_IDLE;
    endfunction

endpackage

// File: rtl/sys_clk_ctrl_if.sv
// sys_clk_ctrl_if: host controls in, system enable and status out
interface sys_clk_ctrl_if #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8,
    parameter int CNT_W   = 32
);
    import sys_clk_ctrl_pkg::*;

    mode_e              mode;
    logic [DIV_W-1:0]   divisor;
    logic [BURST_W-1:0] burst_len;
    logic               host_step;
    logic               sys_ce;
    logic               busy;
    logic [CNT_W-1:0]   ce_count;
    logic               tick_slow;

    modport master (
        output mode, divisor, burst_len, host_step,
        input  sys_ce, busy, ce_count, tick_slow
    );

    modport slave (
        input  mode, divisor, burst_len, host_step,
        output sys_ce, busy, ce_count, tick_slow
    );

endinterface

// File: rtl/sys_clk_ctrl_sync_edge.sv
// sync_edge: multi-flop synchronizer followed by a registered one-cycle rising-edge pulse
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sys_clk_ctrl.sv
// sys_clk_ctrl: single-clock system enable generator (run / step / burst / halt)
// with a wrapping enable counter and a mode-independent heartbeat tick.
module sys_clk_ctrl
    import sys_clk_ctrl_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int BURST_W     = 8,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 100000000
) (
    input logic           clk,
    input logic           rst_n,
    sys_clk_ctrl_if.slave bus
);

    localparam int              TICK_W    = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    mode_e              mode_q;
    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   lim_q, lim_d;
    logic [DIV_W-1:0]   div_eff;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TICK_W-1:0]  tcnt_q, tcnt_d;
    logic               ce_q, ce_d;
    logic               tick_q, tick_d;
    logic               step_evt;
    logic               chg;
    logic               div_hit;
    logic               load;
    logic               counting;
    logic               restart;

    sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.host_step),
        .rise_o  (step_evt)
    );

    assign div_eff = bus.divisor == '0 ? DIV_W'(1) : bus.divisor;
    assign chg     = bus.mode != mode_q;
    assign div_hit = (state_q == ST_RUN || state_q == ST_BURST) && div_q == lim_q - DIV_W'(1);
    assign load    = !chg && state_q == ST_IDLE && mode_q == MODE_BURST && step_evt
                     && bus.burst_len != '0;

    // Out of reset mode_q holds HALT, so any other mode arrives as a change and starts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_HALT;
            state_q <= ST_HALT;
        end else begin
            mode_q  <= bus.mode;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = chg ? base_state(bus.mode)
                : load ? ST_BURST
                : (state_q == ST_BURST && div_hit && rem_q == BURST_W'(1)) ? ST_IDLE
                : state_q;
    end

    // The period limit is latched only at restart so divisor changes land on the next wrap
    always_comb begin
        counting = state_d == ST_RUN || state_d == ST_BURST;
        restart  = div_hit || !counting || state_d != state_q;
        div_d    = restart ? '0 : div_q + DIV_W'(1);
        lim_d    = restart ? div_eff : lim_q;
        rem_d    = chg ? '0
                 : load ? bus.burst_len
                 : (state_q == ST_BURST && div_hit) ? rem_q - BURST_W'(1)
                 : rem_q;
        tcnt_d   = tcnt_q == TICK_LAST ? '0 : tcnt_q + TICK_W'(1);
        tick_d   = tcnt_q == TICK_LAST;
    end

    always_comb begin
        ce_d  = div_hit || (state_q == ST_IDLE && mode_q == MODE_STEP && step_evt);
        cnt_d = cnt_q + CNT_W'(ce_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            lim_q  <= DIV_W'(1);
            rem_q  <= '0;
            cnt_q  <= '0;
            tcnt_q <= '0;
            ce_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            lim_q  <= lim_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
            ce_q   <= ce_d;
            tick_q <= tick_d;
        end
    end

    assign bus.sys_ce    = ce_q;
    assign bus.busy      = state_q == ST_BURST;
    assign bus.ce_count  = cnt_q;
    assign bus.tick_slow = tick_q;

endmodule
